// File: rtl/rgb_mixer_pkg.sv
// Shared constants for the RGB mixer encoder channels: level width,
// Gray-code quadrature states, step direction and the quadrature step decoder.
package rgb_mixer_pkg;

  localparam int unsigned ENC_W = 8;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // +1 for a clockwise Gray step, -1 for counter-clockwise, 0 for no change or illegal jump
  function automatic logic signed [1:0] quarter_of(input logic [1:0] prev, input logic [1:0] curr);
    logic signed [1:0] q;
    q = 2'sb00;
    unique case ({prev, curr})
      {ST_00, ST_10}, {ST_10, ST_11}, {ST_11, ST_01}, {ST_01, ST_00}: q = 2'sb01;
      {ST_00, ST_01}, {ST_01, ST_11}, {ST_11, ST_10}, {ST_10, ST_00}: q = 2'sb11;
      default: q = 2'sb00;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/quad_encoder_counter_if.sv
// Pin-side and level-side signals of one encoder channel; the channel is the slave,
// whoever drives the encoder pins and enable is the master.
interface quad_encoder_counter_if #(
  parameter int unsigned WIDTH = rgb_mixer_pkg::ENC_W
);

  logic             ena;
  logic             enc_a;
  logic             enc_b;
  logic [WIDTH-1:0] value;
  logic             step_pulse;
  logic             step_dir;
  logic             err_pulse;

  modport master (
    output ena, enc_a, enc_b,
    input  value, step_pulse, step_dir, err_pulse
  );

  modport slave (
    input  ena, enc_a, enc_b,
    output value, step_pulse, step_dir, err_pulse
  );

endinterface

// File: rtl/quad_encoder_counter_debounce_sync.sv
// Two-flop synchroniser followed by a stability counter for one raw encoder pin;
// the debounced output only toggles after DEBOUNCE_CYCLES consecutive differing clocks.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic db_o
);

  logic       sync1_q, sync2_q;
  logic       db_q, db_d;
  logic [7:0] cnt_q, cnt_d;

  // Counter restarts whenever the synced pin agrees with the debounced level
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// One encoder channel: debounced quadrature decode, quarter accumulation and a
// saturating (or wrapping) level register feeding a PWM duty input.
module quad_encoder_counter
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH           = ENC_W,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned QUADS_PER_STEP  = 4,
  parameter int unsigned STEP            = 1,
  parameter int unsigned RESET_VALUE     = 0,
  parameter bit          SATURATE        = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  quad_encoder_counter_if.slave enc
);

  localparam logic signed [3:0] QPS    = 4'(QUADS_PER_STEP);
  localparam logic [WIDTH:0]    STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]    MAX_X  = {1'b0, {WIDTH{1'b1}}};

  logic              db_a, db_b;
  logic [1:0]        curr;
  logic [1:0]        prev_q;
  logic signed [1:0] quarter;
  logic signed [3:0] acc_q, acc_d, acc_sum;
  logic [WIDTH-1:0]  value_q, value_d;
  logic [WIDTH:0]    up_sum, dn_diff;
  dir_e              dir_q, dir_d;
  logic              pulse_q, pulse_d;
  logic              err_q, err_d;
  logic              step_up, step_dn;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clk  (clk),
    .rst_n(rst_n),
    .pin_i(enc.enc_a),
    .db_o (db_a)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clk  (clk),
    .rst_n(rst_n),
    .pin_i(enc.enc_b),
    .db_o (db_b)
  );

  assign curr = {db_a, db_b};

  // Accumulator only moves while enabled; prev_q tracks regardless so re-enabling is glitch-free
  always_comb begin
    quarter = quarter_of(prev_q, curr);
    err_d   = ((prev_q ^ curr) == 2'b11);
    acc_sum = acc_q + {{2{quarter[1]}}, quarter};
    acc_d   = acc_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (enc.ena) begin
      acc_d = acc_sum;
      if (acc_sum == QPS) begin
        acc_d   = '0;
        step_up = 1'b1;
      end else if (acc_sum == -QPS) begin
        acc_d   = '0;
        step_dn = 1'b1;
      end
    end

    up_sum  = {1'b0, value_q} + STEP_X;
    dn_diff = {1'b0, value_q} - STEP_X;
    value_d = value_q;
    dir_d   = dir_q;
    if (step_up) begin
      dir_d   = DIR_UP;
      value_d = (SATURATE && (up_sum > MAX_X)) ? {WIDTH{1'b1}} : up_sum[WIDTH-1:0];
    end else if (step_dn) begin
      dir_d   = DIR_DOWN;
      value_d = (SATURATE && dn_diff[WIDTH]) ? '0 : dn_diff[WIDTH-1:0];
    end
    pulse_d = (value_d != value_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= ST_00;
      acc_q   <= '0;
      value_q <= WIDTH'(RESET_VALUE);
      dir_q   <= DIR_DOWN;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= curr;
      acc_q   <= acc_d;
      value_q <= value_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign enc.value      = value_q;
  assign enc.step_pulse = pulse_q;
  assign enc.step_dir   = dir_q;
  assign enc.err_pulse  = err_q;

endmodule
